// File: rtl/btn_evt_pkg.sv
// Shared types and default constants for the button event decoder.
//   state_t   : decoder FSM states
//   lim_sel_t : which interval the shared timer compares against
//   evt_t     : registered output bundle of the decoder
package btn_evt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS1,  // first press held
    ST_WAIT2,   // released, double-click window open
    ST_PRESS2,  // second press held
    ST_LONG     // hold passed the long threshold, auto-repeating
  } state_t;

  typedef enum logic [1:0] {
    LIM_LONG,
    LIM_DCLICK,
    LIM_REPEAT
  } lim_sel_t;

  typedef struct packed {
    logic press;
    logic rel;
    logic click;
    logic dclick;
    logic lng;
    logic rpt;
    logic held;
  } evt_t;

  localparam int DEF_CNT_W         = 27;
  localparam int DEF_LONG_CYCLES   = 100_000_000;  // 1 s at 100 MHz
  localparam int DEF_DCLICK_CYCLES = 25_000_000;
  localparam int DEF_REPEAT_CYCLES = 20_000_000;

endpackage

// File: rtl/btn_evt_timer.sv
// Shared interval counter for the button event decoder.
// Counts while en_i is high, clears on clear_i (priority over counting) and
// flags expire_o in the last cycle of the interval selected by sel_i, i.e.
// when the count equals (interval - 1). The counter saturates instead of
// wrapping.
//   clk, rst  : clock, asynchronous active-high reset
//   clear_i   : synchronous clear of the count
//   en_i      : count enable; expire_o is only raised while enabled
//   sel_i     : interval select (long / double-click / repeat)
//   expire_o  : combinational, high in the final cycle of the interval
module btn_evt_timer
  import btn_evt_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int DCLICK_CYCLES = DEF_DCLICK_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clear_i,
  input  logic     en_i,
  input  lim_sel_t sel_i,
  output logic     expire_o
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last;

  always_comb begin
    case (sel_i)
      LIM_DCLICK: last = DCLICK_LAST;
      LIM_REPEAT: last = REPEAT_LAST;
      default:    last = LONG_LAST;
    endcase
  end

  assign expire_o = en_i && (cnt_q == last);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced, clk-synchronous button level into single-cycle intent
// pulses: press, release, click, double-click, long-press and auto-repeat.
// All outputs are registered, so every pulse appears one cycle after the
// level sample that caused it.
//   clk, rst   : clock, asynchronous active-high reset
//   btn_level  : debounced level, 1 = pressed
//   press_p    : recognized press      release_p : recognized release
//   click_p    : single short click    dclick_p  : double-click
//   long_p     : hold reached LONG     repeat_p  : auto-repeat tick in LONG
//   held       : level, 1 in PRESS1 / PRESS2 / LONG
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int DCLICK_CYCLES = DEF_DCLICK_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic press_p,
  output logic release_p,
  output logic click_p,
  output logic dclick_p,
  output logic long_p,
  output logic repeat_p,
  output logic held
);

  localparam longint CYC_MAX = (longint'(1) << CNT_W) - 1;

  if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) > CYC_MAX) begin : g_bad_long
    $error("LONG_CYCLES out of range 2 .. 2**CNT_W-1");
  end
  if (DCLICK_CYCLES < 2 || longint'(DCLICK_CYCLES) > CYC_MAX) begin : g_bad_dclick
    $error("DCLICK_CYCLES out of range 2 .. 2**CNT_W-1");
  end
  if (REPEAT_CYCLES < 2 || longint'(REPEAT_CYCLES) > CYC_MAX) begin : g_bad_repeat
    $error("REPEAT_CYCLES out of range 2 .. 2**CNT_W-1");
  end

  state_t   state_q, state_d;
  evt_t     evt_q, evt_d;
  logic     prev_q;
  logic     rise, fall;
  logic     tmr_clr, tmr_en, tmr_expire;
  lim_sel_t tmr_sel;

  assign rise = btn_level && !prev_q;
  assign fall = !btn_level && prev_q;

  btn_evt_timer #(
    .CNT_W        (CNT_W),
    .LONG_CYCLES  (LONG_CYCLES),
    .DCLICK_CYCLES(DCLICK_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (tmr_clr),
    .en_i    (tmr_en),
    .sel_i   (tmr_sel),
    .expire_o(tmr_expire)
  );

  // A fall is checked before expiry everywhere: if the button drops in the
  // last cycle of the long interval, the release wins. In WAIT2 a rise in the
  // last window cycle likewise beats the click timeout.
  always_comb begin
    state_d = state_q;
    evt_d   = '0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    tmr_sel = LIM_LONG;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          evt_d.press = 1'b1;
          state_d     = ST_PRESS1;
          tmr_clr     = 1'b1;
        end
      end
      ST_PRESS1, ST_PRESS2: begin
        tmr_en = 1'b1;
        if (fall) begin
          evt_d.rel = 1'b1;
          tmr_clr   = 1'b1;
          if (state_q == ST_PRESS1) begin
            state_d = ST_WAIT2;
          end else begin
            evt_d.dclick = 1'b1;
            state_d      = ST_IDLE;
          end
        end else if (tmr_expire) begin
          evt_d.lng = 1'b1;
          state_d   = ST_LONG;
          tmr_clr   = 1'b1;
        end
      end
      ST_WAIT2: begin
        tmr_en  = 1'b1;
        tmr_sel = LIM_DCLICK;
        if (rise) begin
          evt_d.press = 1'b1;
          state_d     = ST_PRESS2;
          tmr_clr     = 1'b1;
        end else if (tmr_expire) begin
          evt_d.click = 1'b1;
          state_d     = ST_IDLE;
          tmr_clr     = 1'b1;
        end
      end
      ST_LONG: begin
        tmr_en  = 1'b1;
        tmr_sel = LIM_REPEAT;
        if (fall) begin
          evt_d.rel = 1'b1;
          state_d   = ST_IDLE;
          tmr_clr   = 1'b1;
        end else if (tmr_expire) begin
          // Restart the interval so repeats recur every REPEAT_CYCLES.
          evt_d.rpt = 1'b1;
          tmr_clr   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_clr = 1'b1;
      end
    endcase
    evt_d.held = (state_d == ST_PRESS1) || (state_d == ST_PRESS2) ||
                 (state_d == ST_LONG);
  end

  // prev_q resets to 1 so a button held through reset never looks like a
  // rise; it must be seen low first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      evt_q   <= '0;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      prev_q  <= btn_level;
    end
  end

  assign press_p   = evt_q.press;
  assign release_p = evt_q.rel;
  assign click_p   = evt_q.click;
  assign dclick_p  = evt_q.dclick;
  assign long_p    = evt_q.lng;
  assign repeat_p  = evt_q.rpt;
  assign held      = evt_q.held;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder with LONG=8, DCLICK=5,
// REPEAT=4. A timestamp-based reference model predicts every output each
// cycle; directed scenarios additionally pin pulse cycles to literal values.
module tb_button_event_decoder;

  localparam int CNT_W  = 8;
  localparam int LONG   = 8;
  localparam int DCLICK = 5;
  localparam int REPEAT = 4;

  // Bit positions inside the packed output vector.
  localparam int I_PR = 6, I_RL = 5, I_CK = 4, I_DC = 3, I_LG = 2, I_RP = 1, I_HD = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_level = 1'b0;
  logic press_p, release_p, click_p, dclick_p, long_p, repeat_p, held;
  logic [6:0] dut_o;

  button_event_decoder #(
    .CNT_W        (CNT_W),
    .LONG_CYCLES  (LONG),
    .DCLICK_CYCLES(DCLICK),
    .REPEAT_CYCLES(REPEAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_level(btn_level),
    .press_p  (press_p),
    .release_p(release_p),
    .click_p  (click_p),
    .dclick_p (dclick_p),
    .long_p   (long_p),
    .repeat_p (repeat_p),
    .held     (held)
  );

  assign dut_o = {press_p, release_p, click_p, dclick_p, long_p, repeat_p, held};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model (event timestamps) ----------------
  typedef enum int {M_IDLE, M_FIRST, M_GAP, M_SECOND, M_LONG} mphase_t;
  mphase_t    m_ph;
  logic       m_prev;
  int         m_now;
  int         t_press, t_rel, t_long;
  logic [6:0] exp_o;

  task automatic model_reset();
    m_ph   = M_IDLE;
    m_prev = 1'b1;
    exp_o  = '0;
  endtask

  // Given the level of the current cycle, predict the outputs of the next.
  task automatic model_step(input logic b);
    logic rise, fall, pr, rl, ck, dc, lg, rp;
    int   nxt;
    rise = b && !m_prev;
    fall = !b && m_prev;
    nxt  = m_now + 1;
    {pr, rl, ck, dc, lg, rp} = '0;
    case (m_ph)
      M_IDLE: if (rise) begin pr = 1; m_ph = M_FIRST; t_press = nxt; end
      M_FIRST, M_SECOND: begin
        if (fall) begin
          rl = 1;
          if (m_ph == M_FIRST) begin m_ph = M_GAP; t_rel = nxt; end
          else begin dc = 1; m_ph = M_IDLE; end
        end else if (nxt == t_press + LONG) begin
          lg = 1; m_ph = M_LONG; t_long = nxt;
        end
      end
      M_GAP: begin
        if (rise) begin pr = 1; m_ph = M_SECOND; t_press = nxt; end
        else if (nxt == t_rel + DCLICK) begin ck = 1; m_ph = M_IDLE; end
      end
      M_LONG: begin
        if (fall) begin rl = 1; m_ph = M_IDLE; end
        else if ((nxt - t_long) % REPEAT == 0) rp = 1;
      end
      default: m_ph = M_IDLE;
    endcase
    exp_o  = {pr, rl, ck, dc, lg, rp,
              (m_ph == M_FIRST) || (m_ph == M_SECOND) || (m_ph == M_LONG)};
    m_prev = b;
    m_now  = nxt;
  endtask

  // ---------------- per-cycle compare and event log ----------------
  logic [63:0] lg_mask [7];
  int          base = 0;

  task automatic tick();
    int rel;
    @(negedge clk);
    if (rst) model_reset();
    n_cmp++;
    if (dut_o !== exp_o) begin
      n_bad++;
      $display("FAIL cycle %0d outs{pr,rl,ck,dc,lg,rp,hd} got %b exp %b", cyc, dut_o, exp_o);
    end
    rel = cyc - base;
    if (rel >= 0 && rel < 64)
      for (int i = 0; i < 7; i++) lg_mask[i][rel] = dut_o[i];
    if (!rst) model_step(btn_level);
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] at(input int a = -1, input int b = -1, input int c = -1);
    logic [63:0] m;
    m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    return m;
  endfunction

  task automatic check_m(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s pulse-cycle mask got %h want %h", name, got, want);
    end
  endtask

  // Level high in relative cycles [h1a,h1b] and [h2a,h2b], reset in [ra,rb].
  task automatic run_pattern(input int h1a, input int h1b, input int h2a, input int h2b,
                             input int ra, input int rb, input int len);
    logic was_rst;
    for (int i = 0; i < 7; i++) lg_mask[i] = '0;
    base = cyc;
    for (int r = 0; r < len; r++) begin
      was_rst   = rst;
      btn_level = (r >= h1a && r <= h1b) || (r >= h2a && r <= h2b);
      rst       = (r >= ra && r <= rb);
      if (rst && !was_rst) begin
        #1;
        n_cmp++;
        if (dut_o !== 7'b0) begin
          n_bad++;
          $display("FAIL async_reset_clear got %b exp 0000000", dut_o);
        end
      end
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int run;
    model_reset();
    m_now = 0;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (dut_o !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_state got %b exp 0000000", dut_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Single click.
    run_pattern(10, 12, -1, -2, -1, -2, 25);
    check_m("click_press",   lg_mask[I_PR], at(11));
    check_m("click_release", lg_mask[I_RL], at(14));
    check_m("click_click",   lg_mask[I_CK], at(19));
    check_m("click_held",    lg_mask[I_HD], at(11, 12, 13));
    check_m("click_nodc",    lg_mask[I_DC] | lg_mask[I_LG], 64'd0);

    // Double click.
    run_pattern(10, 11, 14, 15, -1, -2, 25);
    check_m("dclick_press",   lg_mask[I_PR], at(11, 15));
    check_m("dclick_release", lg_mask[I_RL], at(13, 17));
    check_m("dclick_dclick",  lg_mask[I_DC], at(17));
    check_m("dclick_noclick", lg_mask[I_CK], 64'd0);

    // Long press with auto-repeat.
    run_pattern(10, 30, -1, -2, -1, -2, 40);
    check_m("long_press",   lg_mask[I_PR], at(11));
    check_m("long_long",    lg_mask[I_LG], at(19));
    check_m("long_repeat",  lg_mask[I_RP], at(23, 27, 31));
    check_m("long_release", lg_mask[I_RL], at(32));
    check_m("long_noclick", lg_mask[I_CK], 64'd0);

    // Fall in the last cycle of the long interval: release wins.
    run_pattern(10, 17, -1, -2, -1, -2, 30);
    check_m("bound_release", lg_mask[I_RL], at(19));
    check_m("bound_nolong",  lg_mask[I_LG], 64'd0);
    check_m("bound_click",   lg_mask[I_CK], at(24));

    // Reset during LONG with the button still held, then a fresh press.
    run_pattern(10, 30, 33, 35, 22, 23, 50);
    check_m("rstlong_press",   lg_mask[I_PR], at(11, 34));
    check_m("rstlong_long",    lg_mask[I_LG], at(19));
    check_m("rstlong_repeat",  lg_mask[I_RP], 64'd0);
    check_m("rstlong_release", lg_mask[I_RL], at(37));
    check_m("rstlong_click",   lg_mask[I_CK], at(42));

    // Button stuck high through reset.
    run_pattern(0, 9, 15, 16, 0, 3, 30);
    check_m("stuck_press",   lg_mask[I_PR], at(16));
    check_m("stuck_release", lg_mask[I_RL], at(18));
    check_m("stuck_click",   lg_mask[I_CK], at(23));

    // Randomized level runs with occasional reset pulses.
    btn_level = 1'b0;
    for (int k = 0; k < 300; k++) begin
      btn_level = ~btn_level;
      run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 30)) : int'($urandom_range(1, 7));
      for (int j = 0; j < run; j++) begin
        rst = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    rst = 1'b0;
    btn_level = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
